// File: rtl/ap_parameters.sv
// Shared widths, sizes and FSM encoding for the FFT magnitude path.
// MAG_HALF_SPECTRUM_EN moves the frame's last emitted bin to FFT_SIZE/2.
package ap_parameters;

  localparam int FFT_DATA_WIDTH = 16;
  localparam int MEL_DATA_WIDTH = 32;
  localparam int MAG_FFT_SIZE   = 512;
  localparam int MAG_ROOT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    ROOT,
    OUT
  } mag_state_t;

  function automatic int last_bin(input int fft_size);
`ifdef MAG_HALF_SPECTRUM_EN
    return fft_size / 2;
`else
    return fft_size - 1;
`endif
  endfunction

endpackage

// File: rtl/magnitude_ctrl_if.sv
// Two valid/ready streams: FFT bins in, magnitudes out.
interface magnitude_ctrl_if
  import ap_parameters::*;
#(
  parameter int FFT_SIZE = MAG_FFT_SIZE
);
  localparam int BIN_W = $clog2(FFT_SIZE);

  logic                             fft_valid;
  logic                             fft_ready;
  logic signed [FFT_DATA_WIDTH-1:0] fft_real;
  logic signed [FFT_DATA_WIDTH-1:0] fft_imag;
  logic                             mag_valid;
  logic                             mag_ready;
  logic [MEL_DATA_WIDTH-1:0]        mag_data;
  logic [BIN_W-1:0]                 mag_bin;
  logic                             mag_last;

  modport master (
    output fft_valid, fft_real, fft_imag, mag_ready,
    input  fft_ready, mag_valid, mag_data, mag_bin, mag_last
  );

  modport slave (
    input  fft_valid, fft_real, fft_imag, mag_ready,
    output fft_ready, mag_valid, mag_data, mag_bin, mag_last
  );

endinterface

// File: rtl/isqrt_serial.sv
// Restoring integer square root, one root bit per cycle, MSB first.
module isqrt_serial #(
  parameter int ROOT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2*ROOT_W-1:0] radicand,
  output logic [ROOT_W-1:0]   root,
  output logic                done
);
  localparam int CNT_W = $clog2(ROOT_W);

  logic [2*ROOT_W-1:0] x;
  logic [ROOT_W+1:0]   rem;
  logic [ROOT_W+1:0]   rem_sh;
  logic [ROOT_W+1:0]   trial;
  logic [ROOT_W+1:0]   diff;
  logic                fits;
  logic [CNT_W-1:0]    cnt;
  logic                running;

  // Before the final step the partial remainder is below 2^ROOT_W, so the
  // two-bit shift never loses significant bits.
  always_comb begin
    rem_sh = (rem << 2) | {{ROOT_W{1'b0}}, x[2*ROOT_W-1 -: 2]};
    trial  = {root, 2'b01};
    fits   = (rem_sh >= trial);
    diff   = rem_sh - trial;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      rem     <= '0;
      root    <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        x       <= radicand;
        rem     <= '0;
        root    <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        x    <= x << 2;
        rem  <= fits ? diff : rem_sh;
        root <= {root[ROOT_W-2:0], fits};
        cnt  <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(ROOT_W - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/magnitude_ctrl.sv
// Sequences FFT bins through square/sum and a serial isqrt, one bin in flight.
// MAG_HALF_SPECTRUM_EN drops bins above FFT_SIZE/2 in a single IDLE cycle.
module magnitude_ctrl
  import ap_parameters::*;
#(
  parameter int FFT_SIZE = MAG_FFT_SIZE,
  parameter int ROOT_W   = MAG_ROOT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  magnitude_ctrl_if.slave  bus,
  output logic             busy
);
  localparam int BIN_W = $clog2(FFT_SIZE);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(last_bin(FFT_SIZE));

  mag_state_t                       state;
  logic signed [FFT_DATA_WIDTH-1:0] re_q;
  logic signed [FFT_DATA_WIDTH-1:0] im_q;
  logic [BIN_W-1:0]                 bin_cnt;
  logic [BIN_W-1:0]                 bin_q;
  logic signed [2*FFT_DATA_WIDTH-1:0] re_sq;
  logic signed [2*FFT_DATA_WIDTH-1:0] im_sq;
  logic [2*FFT_DATA_WIDTH-1:0]      sum;
  logic [ROOT_W-1:0]                root;
  logic                             root_done;
  logic                             accept;
  logic                             drop;

  assign accept = bus.fft_valid && bus.fft_ready;

`ifdef MAG_HALF_SPECTRUM_EN
  assign drop = (bin_cnt > BIN_W'(FFT_SIZE / 2));
`else
  assign drop = 1'b0;
`endif

  // Each square is at most 2^30; the sum peaks at 2^31, read as unsigned.
  always_comb begin
    re_sq = (2*FFT_DATA_WIDTH)'(re_q) * (2*FFT_DATA_WIDTH)'(re_q);
    im_sq = (2*FFT_DATA_WIDTH)'(im_q) * (2*FFT_DATA_WIDTH)'(im_q);
    sum   = unsigned'(re_sq) + unsigned'(im_sq);
  end

  isqrt_serial #(.ROOT_W(ROOT_W)) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state == SQUARE),
    .radicand (sum),
    .root     (root),
    .done     (root_done)
  );

  // NOTE: the latched operands are reset too, so an aborted bin leaves no
  // stale data behind and the outputs read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      re_q          <= '0;
      im_q          <= '0;
      bin_cnt       <= '0;
      bin_q         <= '0;
      busy          <= 1'b0;
      bus.fft_ready <= 1'b1;
      bus.mag_valid <= 1'b0;
      bus.mag_data  <= '0;
      bus.mag_bin   <= '0;
      bus.mag_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            re_q  <= bus.fft_real;
            im_q  <= bus.fft_imag;
            bin_q <= bin_cnt;
            if (drop) begin
              bin_cnt <= bin_cnt + BIN_W'(1);
            end else begin
              state         <= SQUARE;
              busy          <= 1'b1;
              bus.fft_ready <= 1'b0;
            end
          end
        end
        SQUARE: state <= ROOT;
        ROOT: begin
          if (root_done) begin
            state         <= OUT;
            bus.mag_valid <= 1'b1;
            bus.mag_data  <= MEL_DATA_WIDTH'(root);
            bus.mag_bin   <= bin_q;
            bus.mag_last  <= (bin_q == LAST_BIN);
          end
        end
        OUT: begin
          if (bus.mag_ready) begin
            state         <= IDLE;
            busy          <= 1'b0;
            bus.fft_ready <= 1'b1;
            bus.mag_valid <= 1'b0;
            bin_cnt       <= bin_cnt + BIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magnitude_ctrl.sv
// Directed and random bins against a floor(sqrt(re^2+im^2)) reference model.
module tb_magnitude_ctrl;
  import ap_parameters::*;

  localparam int FFT_SIZE = MAG_FFT_SIZE;
`ifdef MAG_HALF_SPECTRUM_EN
  localparam bit HALF = 1'b1;
  localparam int LAST = FFT_SIZE / 2;
`else
  localparam bit HALF = 1'b0;
  localparam int LAST = FFT_SIZE - 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  magnitude_ctrl_if #(.FFT_SIZE(FFT_SIZE)) bus ();

  magnitude_ctrl #(.FFT_SIZE(FFT_SIZE), .ROOT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int exp_bin = 0;
  int outputs = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_mag(input int re, input int im);
    longint s = longint'(re) * re + longint'(im) * im;
    longint r = longint'($floor($sqrt(real'(s))));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (bus.fft_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic do_bin(input logic [15:0] re, input logic [15:0] im, input int stall);
    int     lat = 0;
    longint exp_mag = ref_mag(int'($signed(re)), int'($signed(im)));
    logic [63:0] held_data, held_bin;
    wait_ready();
    if (bus.fft_ready !== 1'b1) begin
      check("ready_timeout", 64'(bus.fft_ready), 64'd1);
      return;
    end
    bus.fft_valid = 1'b1;
    bus.fft_real  = re;
    bus.fft_imag  = im;
    bus.mag_ready = (stall == 0);
    @(posedge clk); #1;
    bus.fft_valid = 1'b0;
    if (HALF && exp_bin > FFT_SIZE / 2) begin
      check("drop_ready", 64'(bus.fft_ready), 64'd1);
      check("drop_no_valid", 64'(bus.mag_valid), 64'd0);
      exp_bin = (exp_bin + 1) % FFT_SIZE;
      return;
    end
    // Garbage offered while busy must never be taken.
    while (bus.mag_valid !== 1'b1 && lat < 40) begin
      bus.fft_valid = 1'($urandom_range(0, 1));
      bus.fft_real  = 16'($urandom);
      bus.fft_imag  = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    bus.fft_valid = 1'b0;
    check("latency", 64'(lat), 64'd18);
    check("mag_data", 64'(bus.mag_data), 64'(exp_mag));
    check("mag_bin", 64'(bus.mag_bin), 64'(exp_bin));
    check("mag_last", 64'(bus.mag_last), 64'(exp_bin == LAST));
    if (bus.mag_valid === 1'b1) outputs++;
    held_data = 64'(bus.mag_data);
    held_bin  = 64'(bus.mag_bin);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(bus.mag_valid), 64'd1);
      check("stall_data", 64'(bus.mag_data), held_data);
      check("stall_bin", 64'(bus.mag_bin), held_bin);
      check("stall_ready", 64'(bus.fft_ready), 64'd0);
    end
    bus.mag_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 64'(bus.mag_valid), 64'd0);
    check("release_ready", 64'(bus.fft_ready), 64'd1);
    check("release_busy", 64'(busy), 64'd0);
    exp_bin = (exp_bin + 1) % FFT_SIZE;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    bus.fft_valid = 1'b0;
    bus.fft_real  = '0;
    bus.fft_imag  = '0;
    bus.mag_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(bus.fft_ready), 64'd1);
    check("rst_valid", 64'(bus.mag_valid), 64'd0);
    check("rst_data", 64'(bus.mag_data), 64'd0);
    check("rst_bin", 64'(bus.mag_bin), 64'd0);
    check("rst_last", 64'(bus.mag_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_bin(16'd3, 16'd4, 0);
    do_bin(16'd0, 16'd0, 0);
    do_bin(16'h8000, 16'h8000, 0);
    do_bin(16'h7fff, 16'h8000, 0);
    do_bin(16'($urandom), 16'($urandom), 10);

    // Abort a bin part-way through the root iterations.
    wait_ready();
    bus.fft_valid = 1'b1;
    bus.fft_real  = 16'd1000;
    bus.fft_imag  = 16'd2000;
    @(posedge clk); #1;
    bus.fft_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(bus.fft_ready), 64'd1);
    check("abort_valid", 64'(bus.mag_valid), 64'd0);
    check("abort_data", 64'(bus.mag_data), 64'd0);
    check("abort_bin", 64'(bus.mag_bin), 64'd0);
    check("abort_last", 64'(bus.mag_last), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.mag_valid !== 1'b0) stale++;
    end
    check("abort_stale_valid", 64'(stale), 64'd0);
    exp_bin = 0;

    outputs = 0;
    for (int i = 0; i < FFT_SIZE; i++) do_bin(16'($urandom), 16'($urandom), 0);
    check("frame_outputs", 64'(outputs), 64'(LAST + 1));
    do_bin(16'($urandom), 16'($urandom), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
